// File: rtl/fd_spi_pkg.sv
// Shared definitions for the Fine Delay mezzanine SPI master: target
// select codes, FSM state type and the chip-select decode helper.
package fd_spi_pkg;

  localparam logic [1:0] c_SPI_SEL_DAC  = 2'd0;
  localparam logic [1:0] c_SPI_SEL_PLL  = 2'd1;
  localparam logic [1:0] c_SPI_SEL_GPIO = 2'd2;
  localparam logic [1:0] c_SPI_SEL_RSVD = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    GAP      = 3'd4
  } t_spi_state;

  // Active-low chip-select vector {gpio, pll, dac}; the reserved code selects nothing.
  function automatic logic [2:0] f_cs_n(input logic [1:0] sel);
    logic [2:0] cs_n;
    cs_n = 3'b111;
    case (sel)
      c_SPI_SEL_DAC:  cs_n = 3'b110;
      c_SPI_SEL_PLL:  cs_n = 3'b101;
      c_SPI_SEL_GPIO: cs_n = 3'b011;
      default:        cs_n = 3'b111;
    endcase
    return cs_n;
  endfunction

endpackage

// File: rtl/fd_spi_master.sv
// Mode-0, MSB-first SPI master with three chip selects. A one-cycle start
// request in IDLE launches one fixed-length frame; MISO is gathered on SCLK
// rising edges and presented on rdata_o together with the done_o pulse.
//
// Handshake: start_i is taken only on a cycle where busy_o reads 0 and
// sel_i is not the reserved code; any other start_i is silently dropped.
// busy_o stays high from the accepting edge until the frame's trailing gap
// has elapsed, and done_o marks the single cycle in which rdata_o is new.
module fd_spi_master
  import fd_spi_pkg::*;
#(
  parameter int g_div  = 4,
  parameter int g_bits = 24
) (
  input  logic              clk_sys_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [1:0]        sel_i,
  input  logic [g_bits-1:0] data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [g_bits-1:0] rdata_o,
  output logic              spi_sclk_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i,
  output logic              spi_cs_dac_n_o,
  output logic              spi_cs_pll_n_o,
  output logic              spi_cs_gpio_n_o
);

  localparam int c_CW = $clog2(g_div + 1);
  localparam int c_BW = $clog2(2 * g_bits + 1);
  localparam logic [c_CW-1:0] c_DIV_LOAD  = c_CW'(g_div - 1);
  localparam logic [c_BW-1:0] c_HALF_LAST = c_BW'(2 * g_bits);
  localparam logic [c_BW-1:0] c_HALF_FALL = c_BW'(2 * g_bits - 1);

  t_spi_state        state_q;
  logic [c_CW-1:0]   div_q;
  logic [c_BW-1:0]   half_q;
  logic [g_bits-1:0] tx_q;
  logic [g_bits-1:0] rx_q;
  logic [g_bits-1:0] rdata_q;
  logic [2:0]        cs_n_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;
  logic              tick_d;

  // A phase ends when the half-period down-counter has run out.
  always_comb begin
    tick_d = (div_q == '0);
  end

  // Frame sequencer: divider, half-period count, shift registers and all pins.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      half_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      cs_n_q  <= 3'b111;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) begin
        div_q <= tick_d ? c_DIV_LOAD : div_q - 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start_i && (sel_i != c_SPI_SEL_RSVD)) begin
            state_q <= CS_SETUP;
            div_q   <= c_DIV_LOAD;
            half_q  <= '0;
            tx_q    <= data_i;
            rx_q    <= '0;
            cs_n_q  <= f_cs_n(sel_i);
            mosi_q  <= data_i[g_bits-1];
            busy_q  <= 1'b1;
          end
        end
        CS_SETUP: begin
          // Leaving setup is the first rising SCLK edge, so MISO is taken here too.
          if (tick_d) begin
            state_q <= SHIFT;
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[g_bits-2:0], spi_miso_i};
            half_q  <= c_BW'(1);
          end
        end
        SHIFT: begin
          if (tick_d) begin
            if (half_q == c_HALF_LAST) begin
              state_q <= CS_HOLD;
            end else if (sclk_q) begin
              sclk_q <= 1'b0;
              half_q <= half_q + 1'b1;
              // The final falling edge leaves MOSI on bit 0 rather than shifting in a zero.
              if (half_q != c_HALF_FALL) begin
                tx_q   <= {tx_q[g_bits-2:0], 1'b0};
                mosi_q <= tx_q[g_bits-2];
              end
            end else begin
              sclk_q <= 1'b1;
              half_q <= half_q + 1'b1;
              rx_q   <= {rx_q[g_bits-2:0], spi_miso_i};
            end
          end
        end
        CS_HOLD: begin
          if (tick_d) begin
            state_q <= GAP;
            cs_n_q  <= 3'b111;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
            rdata_q <= rx_q;
          end
        end
        GAP: begin
          if (tick_d) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign rdata_o         = rdata_q;
  assign spi_sclk_o      = sclk_q;
  assign spi_mosi_o      = mosi_q;
  assign spi_cs_dac_n_o  = cs_n_q[0];
  assign spi_cs_pll_n_o  = cs_n_q[1];
  assign spi_cs_gpio_n_o = cs_n_q[2];

endmodule

// File: tb/tb_fd_spi_master.sv
// Bench for fd_spi_master: a behavioural SPI slave answers on the bus, and
// every frame is judged against the frame shape expected from its length,
// divider and target (CS window, SCLK count, done/busy cycles, data both ways).
module tb_fd_spi_master;
  import fd_spi_pkg::*;

  localparam int G_DIV     = 4;
  localparam int G_BITS    = 24;
  localparam int L_CS      = (2 * G_BITS + 2) * G_DIV;  // cycles CS is low
  localparam int C_DONE    = L_CS + 1;                  // cycle of done_o
  localparam int C_RISE    = G_DIV + 1;                 // first SCLK high cycle
  localparam int C_IDLE    = C_DONE + G_DIV;            // first cycle busy_o is 0
  localparam int C_PERIOD  = C_IDLE;                    // back-to-back frame period

  // ---------------- clock / reset ----------------
  logic              clk_sys_i = 1'b0;
  logic              rst_n_i   = 1'b0;
  logic              start_i   = 1'b0;
  logic [1:0]        sel_i     = 2'd0;
  logic [G_BITS-1:0] data_i    = '0;
  logic              busy_o;
  logic              done_o;
  logic [G_BITS-1:0] rdata_o;
  logic              spi_sclk_o;
  logic              spi_mosi_o;
  logic              spi_miso_i = 1'b0;
  logic              spi_cs_dac_n_o;
  logic              spi_cs_pll_n_o;
  logic              spi_cs_gpio_n_o;

  always #5 clk_sys_i = ~clk_sys_i;

  fd_spi_master #(.g_div(G_DIV), .g_bits(G_BITS)) dut (
    .clk_sys_i       (clk_sys_i),
    .rst_n_i         (rst_n_i),
    .start_i         (start_i),
    .sel_i           (sel_i),
    .data_i          (data_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .rdata_o         (rdata_o),
    .spi_sclk_o      (spi_sclk_o),
    .spi_mosi_o      (spi_mosi_o),
    .spi_miso_i      (spi_miso_i),
    .spi_cs_dac_n_o  (spi_cs_dac_n_o),
    .spi_cs_pll_n_o  (spi_cs_pll_n_o),
    .spi_cs_gpio_n_o (spi_cs_gpio_n_o)
  );

  logic cs_all;
  assign cs_all = spi_cs_dac_n_o & spi_cs_pll_n_o & spi_cs_gpio_n_o;

  // ---------------- scoreboard / checker ----------------
  int total_cnt = 0;
  int bad_cnt   = 0;
  logic [G_BITS-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural SPI slave (mode 0) ----------------
  // Presents its MSB when any CS falls, moves to the next bit on each SCLK
  // fall, and shifts MOSI in on each SCLK rise.
  logic [G_BITS-1:0] s_word = '0;
  logic [G_BITS-1:0] s_rx   = '0;
  int                s_idx  = 0;
  int                s_rises = 0;
  logic              s_cs_prev   = 1'b1;
  logic              s_sclk_prev = 1'b0;

  always @(cs_all or spi_sclk_o) begin
    if (s_cs_prev === 1'b1 && cs_all === 1'b0) begin
      s_idx      = G_BITS - 1;
      s_rx       = '0;
      s_rises    = 0;
      spi_miso_i = s_word[s_idx];
    end else if (cs_all === 1'b0 && s_sclk_prev === 1'b1 && spi_sclk_o === 1'b0) begin
      if (s_idx > 0) s_idx--;
      spi_miso_i = s_word[s_idx];
    end else if (cs_all === 1'b0 && s_sclk_prev === 1'b0 && spi_sclk_o === 1'b1) begin
      s_rx = {s_rx[G_BITS-2:0], spi_mosi_o};
      s_rises++;
    end
    s_cs_prev   = cs_all;
    s_sclk_prev = spi_sclk_o;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk_sys_i);
    while (busy_o && n < 500) begin
      @(negedge clk_sys_i);
      n++;
    end
    if (busy_o) check_eq("idle_timeout", busy_o, 1'b0);
  endtask

  // One frame, observed cycle by cycle; cycle 1 is the first after the accepting edge.
  task automatic do_frame(input logic [1:0] sel, input logic [G_BITS-1:0] data,
                          input logic [G_BITS-1:0] word, input string tag);
    int cs_low[3];
    int done_cyc, done_cnt, busy_fall, first_rise, mosi_bad, multi_cs, lows;
    logic prev_mosi;
    logic [G_BITS-1:0] got_rdata;
    logic [G_BITS-1:0] exp_rd;
    cs_low = '{0, 0, 0};
    done_cyc = 0; done_cnt = 0; busy_fall = 0; first_rise = 0;
    mosi_bad = 0; multi_cs = 0; prev_mosi = 1'b0; got_rdata = '0;
    wait_idle();
    s_word = word;
    exp_q.push_back(word);
    start_i = 1'b1; sel_i = sel; data_i = data;
    for (int cyc = 1; cyc <= C_IDLE + 60; cyc++) begin
      @(negedge clk_sys_i);
      if (cyc == 1) begin
        start_i   = 1'b0;
        data_i    = G_BITS'($urandom);
        prev_mosi = spi_mosi_o;
      end
      lows = 0;
      if (!spi_cs_dac_n_o)  begin cs_low[0]++; lows++; end
      if (!spi_cs_pll_n_o)  begin cs_low[1]++; lows++; end
      if (!spi_cs_gpio_n_o) begin cs_low[2]++; lows++; end
      if (lows > 1) multi_cs++;
      if (spi_sclk_o && first_rise == 0) first_rise = cyc;
      if (spi_mosi_o !== prev_mosi && spi_sclk_o) mosi_bad++;
      prev_mosi = spi_mosi_o;
      if (done_o) begin
        done_cnt++;
        done_cyc  = cyc;
        got_rdata = rdata_o;
      end
      if (!busy_o) begin
        busy_fall = cyc;
        break;
      end
    end
    exp_rd = exp_q.pop_front();
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("%s_cs%0d_low", tag, i), cs_low[i], (i == int'(sel)) ? L_CS : 0);
    check_eq({tag, "_done_cyc"},   done_cyc,   C_DONE);
    check_eq({tag, "_done_cnt"},   done_cnt,   1);
    check_eq({tag, "_first_rise"}, first_rise, C_RISE);
    check_eq({tag, "_busy_fall"},  busy_fall,  C_IDLE);
    check_eq({tag, "_rdata"},      got_rdata,  exp_rd);
    check_eq({tag, "_rdata_hold"}, rdata_o,    exp_rd);
    check_eq({tag, "_slave_rx"},   s_rx,       data);
    check_eq({tag, "_rises"},      s_rises,    G_BITS);
    check_eq({tag, "_mosi_hi"},    mosi_bad,   0);
    check_eq({tag, "_multi_cs"},   multi_cs,   0);
  endtask

  // start_i held high with sel toggling 0/1 every cycle, for three frames.
  task automatic run_b2b();
    int falls, dones, bad_len, multi, min_gap, gap, run, cyc, third, gpio_low, lows;
    logic prev_all;
    falls = 0; dones = 0; bad_len = 0; multi = 0; min_gap = 1000;
    gap = 0; run = 0; cyc = 0; third = 0; gpio_low = 0; prev_all = 1'b1;
    wait_idle();
    s_word  = G_BITS'($urandom);
    start_i = 1'b1; sel_i = c_SPI_SEL_DAC; data_i = G_BITS'($urandom);
    while (dones < 3 && cyc < 1000) begin
      @(negedge clk_sys_i);
      cyc++;
      lows = int'(!spi_cs_dac_n_o) + int'(!spi_cs_pll_n_o) + int'(!spi_cs_gpio_n_o);
      if (lows > 1) multi++;
      if (!spi_cs_gpio_n_o) gpio_low++;
      if (cs_all) begin
        if (!prev_all && run != L_CS) bad_len++;
        gap++;
      end else begin
        if (prev_all) begin
          falls++;
          if (falls > 1 && gap < min_gap) min_gap = gap;
          gap = 0;
          run = 0;
        end
        run++;
      end
      prev_all = cs_all;
      if (done_o) begin
        dones++;
        if (dones == 3) third = cyc;
      end
      sel_i  = (cyc % 2 == 1) ? c_SPI_SEL_PLL : c_SPI_SEL_DAC;
      data_i = G_BITS'($urandom);
    end
    start_i = 1'b0;
    check_eq("b2b_falls",     falls,            3);
    check_eq("b2b_third_done", third,           2 * C_PERIOD + C_DONE);
    check_eq("b2b_gap_ok",    min_gap >= G_DIV, 1'b1);
    check_eq("b2b_len",       bad_len,          0);
    check_eq("b2b_overlap",   multi,            0);
    check_eq("b2b_gpio",      gpio_low,         0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int act;
    int dn;
    logic [G_BITS-1:0] d;
    logic [G_BITS-1:0] w;

    // Reset values while rst_n_i is held low.
    #12;
    check_eq("rst_cs", {spi_cs_gpio_n_o, spi_cs_pll_n_o, spi_cs_dac_n_o}, 3'b111);
    check_eq("rst_pins", {spi_sclk_o, spi_mosi_o, busy_o, done_o}, 4'b0000);
    check_eq("rst_rdata", rdata_o, 0);
    @(negedge clk_sys_i);
    rst_n_i = 1'b1;

    // Idle with no request: nothing moves for 100 cycles.
    act = 0;
    repeat (100) begin
      @(negedge clk_sys_i);
      if (!cs_all || spi_sclk_o || busy_o || done_o || spi_mosi_o) act++;
    end
    check_eq("idle_activity", act, 0);

    // Directed GPIO write with MISO readback.
    do_frame(c_SPI_SEL_GPIO, 24'h0000A5, 24'h5A3C81, "gpio");

    // Randomised frames to all three targets.
    for (int k = 0; k < 6; k++) begin
      d = G_BITS'($urandom);
      w = G_BITS'($urandom);
      do_frame(2'($urandom_range(0, 2)), d, w, $sformatf("rnd%0d", k));
    end

    run_b2b();

    // Reserved select: request is dropped and the bus stays quiet.
    wait_idle();
    act = 0;
    start_i = 1'b1; sel_i = c_SPI_SEL_RSVD; data_i = G_BITS'($urandom);
    repeat (12) begin
      @(negedge clk_sys_i);
      if (busy_o || !cs_all || spi_sclk_o || done_o || spi_mosi_o) act++;
    end
    start_i = 1'b0;
    check_eq("inv_activity", act, 0);

    // Reset in the middle of a PLL frame, around cycle 60 while SCLK is high.
    wait_idle();
    s_word  = G_BITS'($urandom);
    start_i = 1'b1; sel_i = c_SPI_SEL_PLL; data_i = G_BITS'($urandom);
    @(negedge clk_sys_i);
    start_i = 1'b0;
    repeat (60) @(negedge clk_sys_i);
    check_eq("pre_rst_sclk", spi_sclk_o, 1'b1);
    check_eq("pre_rst_cs_pll", spi_cs_pll_n_o, 1'b0);
    #1 rst_n_i = 1'b0;
    #1;
    check_eq("mid_rst_cs_pll", spi_cs_pll_n_o, 1'b1);
    check_eq("mid_rst_sclk", spi_sclk_o, 1'b0);
    check_eq("mid_rst_busy", busy_o, 1'b0);
    check_eq("mid_rst_rdata", rdata_o, 0);
    dn = 0;
    repeat (3) begin
      @(negedge clk_sys_i);
      if (done_o) dn++;
    end
    rst_n_i = 1'b1;
    repeat (3) begin
      @(negedge clk_sys_i);
      if (done_o) dn++;
    end
    check_eq("mid_rst_no_done", dn, 0);

    // A fresh DAC frame after the interrupted one.
    d = G_BITS'($urandom);
    w = G_BITS'($urandom);
    do_frame(c_SPI_SEL_DAC, d, w, "post_rst");

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad_cnt);
    $fatal(1, "watchdog");
  end

endmodule
